frame_capture_ctrl: RTL and testbench

- Sequences writes into the 320x240 grayscale frame buffer.
- LIVE mode: streams continuously. On a capture request it waits for a frame boundary, writes exactly one complete frame, then freezes the buffer and hands it to downstream processing until released.
- Sits between the camera/rotate path (pixel and frame-done strobes) and the frame buffer write enable. It also provides the "frame ready" handshake for the post-start-screen processing stage.

---
 rtl/frame_capture_ctrl.sv | 173 +++++++++++++++++
 tb/tb_frame_capture_ctrl.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/frame_capture_ctrl.sv
// Frame capture sequencer: gates frame buffer writes in LIVE mode and captures one
// verified full frame on request, freezing it for downstream processing until released.
module frame_capture_ctrl #(
  parameter int FRAME_PIXELS   = 76800,
  parameter int MAX_RETRIES    = 3,
  parameter int TIMEOUT_CYCLES = 4000000
) (
  input  logic        clk_65mhz,
  input  logic        sys_rst,
  input  logic        capture_in,
  input  logic        live_en_in,
  input  logic        pixel_valid_in,
  input  logic        frame_done_in,
  input  logic        release_in,
  output logic        wr_en_out,
  output logic        frame_ready_out,
  output logic        capture_done_out,
  output logic [1:0]  state_out,
  output logic [16:0] pixel_count_out,
  output logic [1:0]  retry_count_out,
  output logic        error_out
);

  localparam int TW = $clog2(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TIMEOUT_LAST = TW'(TIMEOUT_CYCLES - 1);
  localparam logic [16:0]   PIX_MAX      = 17'h1FFFF;
  localparam logic [16:0]   FRAME_CNT    = 17'(FRAME_PIXELS);
  localparam logic [1:0]    RETRY_LIMIT  = 2'(MAX_RETRIES);

  typedef enum logic [1:0] {
    ST_LIVE    = 2'd0,
    ST_ARMED   = 2'd1,
    ST_CAPTURE = 2'd2,
    ST_HOLD    = 2'd3
  } state_t;

  state_t        state_reg, state_next;
  logic          capture_q_reg;
  logic          wr_en_reg, wr_en_next;
  logic          frame_ready_reg, frame_ready_next;
  logic          capture_done_reg, capture_done_next;
  logic [16:0]   pixel_count_reg, pixel_count_next;
  logic [1:0]    retry_count_reg, retry_count_next;
  logic          error_reg, error_next;
  logic [TW-1:0] timeout_reg, timeout_next;

  logic          cap_edge;
  logic          timeout_hit;
  logic [16:0]   pix_inc;
  logic [16:0]   final_count;

  assign cap_edge    = capture_in & ~capture_q_reg;
  assign timeout_hit = (timeout_reg == TIMEOUT_LAST);
  assign pix_inc     = (pixel_count_reg == PIX_MAX) ? pixel_count_reg : pixel_count_reg + 17'd1;
  // A strobe arriving with frame_done belongs to the frame that is ending.
  assign final_count = pixel_valid_in ? pix_inc : pixel_count_reg;

  always_ff @(posedge clk_65mhz) begin
    if (sys_rst) begin
      state_reg        <= ST_LIVE;
      capture_q_reg    <= 1'b0;
      wr_en_reg        <= 1'b0;
      frame_ready_reg  <= 1'b0;
      capture_done_reg <= 1'b0;
      pixel_count_reg  <= '0;
      retry_count_reg  <= '0;
      error_reg        <= 1'b0;
      timeout_reg      <= '0;
    end else begin
      state_reg        <= state_next;
      capture_q_reg    <= capture_in;
      wr_en_reg        <= wr_en_next;
      frame_ready_reg  <= frame_ready_next;
      capture_done_reg <= capture_done_next;
      pixel_count_reg  <= pixel_count_next;
      retry_count_reg  <= retry_count_next;
      error_reg        <= error_next;
      timeout_reg      <= timeout_next;
    end
  end

  always_comb begin
    state_next        = state_reg;
    wr_en_next        = wr_en_reg;
    frame_ready_next  = frame_ready_reg;
    capture_done_next = 1'b0;
    pixel_count_next  = pixel_count_reg;
    retry_count_next  = retry_count_reg;
    error_next        = error_reg;
    timeout_next      = '0;

    case (state_reg)
      ST_LIVE: begin
        wr_en_next       = live_en_in;
        frame_ready_next = 1'b0;
        if (cap_edge) begin
          state_next       = ST_ARMED;
          wr_en_next       = 1'b0;
          error_next       = 1'b0;
          retry_count_next = '0;
        end
      end

      ST_ARMED: begin
        wr_en_next   = 1'b0;
        timeout_next = timeout_reg + TW'(1);
        if (frame_done_in) begin
          state_next       = ST_CAPTURE;
          pixel_count_next = '0;
          timeout_next     = '0;
          wr_en_next       = 1'b1;
        end else if (timeout_hit) begin
          state_next   = ST_LIVE;
          error_next   = 1'b1;
          timeout_next = '0;
        end
      end

      ST_CAPTURE: begin
        wr_en_next       = 1'b1;
        pixel_count_next = final_count;
        timeout_next     = timeout_reg + TW'(1);
        if (frame_done_in) begin
          timeout_next = '0;
          if (final_count == FRAME_CNT) begin
            state_next        = ST_HOLD;
            wr_en_next        = 1'b0;
            frame_ready_next  = 1'b1;
            capture_done_next = 1'b1;
          end else if (retry_count_reg < RETRY_LIMIT) begin
            retry_count_next = retry_count_reg + 2'd1;
            pixel_count_next = '0;
          end else begin
            state_next = ST_LIVE;
            wr_en_next = 1'b0;
            error_next = 1'b1;
          end
        end else if (timeout_hit) begin
          state_next   = ST_LIVE;
          wr_en_next   = 1'b0;
          error_next   = 1'b1;
          timeout_next = '0;
        end
      end

      ST_HOLD: begin
        wr_en_next       = 1'b0;
        frame_ready_next = 1'b1;
        // Recapture takes priority over a simultaneous release.
        if (cap_edge) begin
          state_next       = ST_ARMED;
          frame_ready_next = 1'b0;
          error_next       = 1'b0;
          retry_count_next = '0;
        end else if (release_in) begin
          state_next       = ST_LIVE;
          frame_ready_next = 1'b0;
        end
      end

      default: state_next = ST_LIVE;
    endcase
  end

  assign wr_en_out        = wr_en_reg;
  assign frame_ready_out  = frame_ready_reg;
  assign capture_done_out = capture_done_reg;
  assign state_out        = state_reg;
  assign pixel_count_out  = pixel_count_reg;
  assign retry_count_out  = retry_count_reg;
  assign error_out        = error_reg;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Directed and randomized checks of frame_capture_ctrl against a frame-level outcome model.
module tb_frame_capture_ctrl;

  localparam int FP = 16;
  localparam int MR = 3;
  localparam int TO = 100;

  logic        clk_65mhz = 1'b0;
  logic        sys_rst, capture_in, live_en_in, pixel_valid_in, frame_done_in, release_in;
  logic        wr_en_out, frame_ready_out, capture_done_out, error_out;
  logic [1:0]  state_out, retry_count_out;
  logic [16:0] pixel_count_out;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk_65mhz = ~clk_65mhz;

  frame_capture_ctrl #(
    .FRAME_PIXELS(FP),
    .MAX_RETRIES(MR),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk_65mhz(clk_65mhz),
    .sys_rst(sys_rst),
    .capture_in(capture_in),
    .live_en_in(live_en_in),
    .pixel_valid_in(pixel_valid_in),
    .frame_done_in(frame_done_in),
    .release_in(release_in),
    .wr_en_out(wr_en_out),
    .frame_ready_out(frame_ready_out),
    .capture_done_out(capture_done_out),
    .state_out(state_out),
    .pixel_count_out(pixel_count_out),
    .retry_count_out(retry_count_out),
    .error_out(error_out)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests_run++;
    assert (obs === exp)
    else begin
      tests_failed++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag, input int st, input int wr, input int fr,
                           input int cd, input int pc, input int rc, input int er);
    check({tag, ".state"}, 32'(state_out), 32'(st));
    check({tag, ".wr_en"}, 32'(wr_en_out), 32'(wr));
    check({tag, ".frame_ready"}, 32'(frame_ready_out), 32'(fr));
    check({tag, ".capture_done"}, 32'(capture_done_out), 32'(cd));
    check({tag, ".pixel_count"}, 32'(pixel_count_out), 32'(pc));
    check({tag, ".retry_count"}, 32'(retry_count_out), 32'(rc));
    check({tag, ".error"}, 32'(error_out), 32'(er));
  endtask

  // Inputs change at negedge; outputs are sampled at the following negedge.
  task automatic tick(input logic pv, input logic fd, input logic rel);
    pixel_valid_in = pv;
    frame_done_in  = fd;
    release_in     = rel;
    @(posedge clk_65mhz);
    @(negedge clk_65mhz);
    pixel_valid_in = 1'b0;
    frame_done_in  = 1'b0;
    release_in     = 1'b0;
  endtask

  initial begin
    int  cnt;
    bit  coincide;
    bit  done;
    bit  held;
    sys_rst        = 1'b1;
    capture_in     = 1'b0;
    live_en_in     = 1'b1;
    pixel_valid_in = 1'b0;
    frame_done_in  = 1'b0;
    release_in     = 1'b0;
    @(negedge clk_65mhz);
    tick(0, 0, 0);
    tick(0, 0, 0);
    check_all("reset", 0, 0, 0, 0, 0, 0, 0);

    sys_rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      tick(0, 0, 0);
      check_all("idle", 0, 1, 0, 0, 0, 0, 0);
    end

    // Basic capture: LIVE -> ARMED -> CAPTURE -> HOLD -> LIVE
    capture_in = 1'b1;
    tick(0, 0, 0);
    check_all("armed", 1, 0, 0, 0, 0, 0, 0);
    tick(0, 1, 0);
    check_all("capture", 2, 1, 0, 0, 0, 0, 0);
    for (int i = 0; i < FP; i++) tick(1, 0, 0);
    check("basic.count", 32'(pixel_count_out), 32'(FP));
    tick(0, 1, 0);
    check_all("hold", 3, 0, 1, 1, FP, 0, 0);
    tick(0, 0, 0);
    check_all("hold2", 3, 0, 1, 0, FP, 0, 0);
    tick(0, 0, 1);
    check("release.state", 32'(state_out), 32'd0);
    check("release.ready", 32'(frame_ready_out), 32'd0);
    capture_in = 1'b0;
    tick(0, 0, 0);

    // Short frames exhaust retries
    capture_in = 1'b1;
    tick(0, 0, 0);
    tick(0, 1, 0);
    check("short.state", 32'(state_out), 32'd2);
    for (int r = 1; r <= MR + 1; r++) begin
      for (int i = 0; i < FP - 1; i++) tick(1, 0, 0);
      tick(0, 1, 0);
      if (r <= MR) check_all("short.retry", 2, 1, 0, 0, 0, r, 0);
      else         check_all("short.fail", 0, 0, 0, 0, FP - 1, MR, 1);
    end
    capture_in = 1'b0;
    tick(0, 0, 0);
    capture_in = 1'b1;
    tick(0, 0, 0);
    check_all("err_clear", 1, 0, 0, 0, FP - 1, 0, 0);

    // Last pixel coincident with frame_done
    tick(0, 1, 0);
    for (int i = 0; i < FP - 1; i++) tick(1, 0, 0);
    tick(1, 1, 0);
    check_all("coincide", 3, 0, 1, 1, FP, 0, 0);

    // Capture edge and release together in HOLD
    capture_in = 1'b0;
    tick(0, 0, 0);
    check("hold_wait.state", 32'(state_out), 32'd3);
    capture_in = 1'b1;
    tick(0, 0, 1);
    check("cap_rel.state", 32'(state_out), 32'd1);
    check("cap_rel.ready", 32'(frame_ready_out), 32'd0);

    // ARMED timeout
    repeat (TO - 1) tick(0, 0, 0);
    check("timeout.pre", 32'(state_out), 32'd1);
    tick(0, 0, 0);
    check("timeout.state", 32'(state_out), 32'd0);
    check("timeout.error", 32'(error_out), 32'd1);

    // Reset mid-capture
    capture_in = 1'b0;
    tick(0, 0, 0);
    capture_in = 1'b1;
    tick(0, 0, 0);
    tick(0, 1, 0);
    for (int i = 0; i < 8; i++) tick(1, 0, 0);
    check("midcap.count", 32'(pixel_count_out), 32'd8);
    sys_rst = 1'b1;
    tick(0, 0, 0);
    check_all("midcap.reset", 0, 0, 0, 0, 0, 0, 0);
    sys_rst    = 1'b0;
    capture_in = 1'b0;
    tick(0, 0, 0);

    // Randomized captures: outcome is the first full frame among up to MR+1 frames
    for (int n = 0; n < 20; n++) begin
      capture_in = 1'b0;
      tick(0, 0, 0);
      capture_in = 1'b1;
      tick(0, 0, 0);
      check("rnd.armed", 32'(state_out), 32'd1);
      repeat ($urandom_range(0, 5)) tick(1'($urandom_range(0, 1)), 0, 0);
      tick(0, 1, 0);
      check_all("rnd.capture", 2, 1, 0, 0, 0, 0, 0);
      done = 1'b0;
      held = 1'b0;
      for (int f = 0; f <= MR && !done; f++) begin
        cnt      = ($urandom_range(0, 1) == 1) ? FP : int'($urandom_range(0, FP + 4));
        coincide = (cnt > 0) && ($urandom_range(0, 1) == 1);
        for (int p = 0; p < cnt - int'(coincide); p++) begin
          repeat ($urandom_range(0, 2)) tick(0, 0, 1'($urandom_range(0, 1)));
          tick(1, 0, 0);
        end
        tick(coincide, 1, 0);
        if (cnt == FP) begin
          check_all("rnd.hold", 3, 0, 1, 1, FP, f, 0);
          done = 1'b1;
          held = 1'b1;
        end else if (f < MR) begin
          check_all("rnd.retry", 2, 1, 0, 0, 0, f + 1, 0);
        end else begin
          check_all("rnd.fail", 0, 0, 0, 0, cnt, MR, 1);
          done = 1'b1;
        end
      end
      if (held) begin
        repeat ($urandom_range(0, 3)) tick(0, 0, 0);
        tick(0, 0, 1);
        check("rnd.release", 32'(state_out), 32'd0);
      end
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
